// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   - DM access-type codes driven on DM_type (Word_DM is the only code the
//     DMA engine ever issues).
//   - Arbiter FSM state encoding.
//   - DM geometry: 3072 words, highest legal byte address 0x2FFF.
package dm_arbiter_pkg;

  localparam logic [5:0] Word_DM  = 6'b000001;
  localparam logic [5:0] Half_DM  = 6'b000010;
  localparam logic [5:0] Halfu_DM = 6'b000100;
  localparam logic [5:0] Byte_DM  = 6'b001000;
  localparam logic [5:0] Byteu_DM = 6'b010000;

  localparam int          DM_WORDS      = 3072;
  localparam logic [31:0] DM_ADDR_LIMIT = 32'(DM_WORDS * 4 - 1);

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_t;

  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/dm_arbiter_dma_addr_chk.sv
// Combinational legality check for a DMA beat address.
//   addr : DMA byte address
//   bad  : 1 when addr lies above ADDR_LIMIT or is not word aligned
module dma_addr_chk
  import dm_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = DM_ADDR_LIMIT
) (
  input  logic [31:0] addr,
  output logic        bad
);

  assign bad = (addr > ADDR_LIMIT) | word_misaligned(addr[1:0]);

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the CPU MEM stage (C, default owner) and a
// word-only burst DMA/loader engine (D).
//   clk, reset          : clock, synchronous active-high reset
//   cpu_*               : C request/write/address/data/type, cpu_rd read data,
//                         cpu_stall freezes MEM and upstream while D owns the DM
//   dma_req/dma_gnt     : D beat handshake (see below)
//   dma_we/addr/wd/last : D beat attributes
//   dma_rvalid/rdata    : registered read return, one cycle after the grant
//   dma_err             : registered, accepted beat was out of range/misaligned
//   dm_*                : muxed DM port, dm_rd is the DM combinational read
//   dbg_state/dbg_wait_cnt/dbg_beat_cnt : FSM state and counters for checkers
//
// D handshake: dma_req is valid for a beat whose attributes are held stable
// until dma_gnt is seen high in the same cycle; a beat transfers exactly on a
// cycle with dma_req & dma_gnt. dma_gnt never depends on anything but
// dma_req and the registered state, so D may not withdraw a beat it has
// presented except by dropping dma_req (which ends the ownership period).
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int          MAX_WAIT   = 4,
  parameter int          BURST_MAX  = 8,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic [5:0]  cpu_type,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [5:0]  dm_type,
  input  logic [31:0] dm_rd,
  output arb_state_t  dbg_state,
  output logic [7:0]  dbg_wait_cnt,
  output logic [7:0]  dbg_beat_cnt
);

  arb_state_t state;
  logic [7:0] wait_cnt;
  logic [7:0] beat_cnt;
  logic       bad;
  logic       in_dma;
  logic       burst_done;

  dma_addr_chk #(.ADDR_LIMIT(ADDR_LIMIT)) u_chk (
    .addr (dma_addr),
    .bad  (bad)
  );

  assign in_dma    = (state == S_DMA);
  assign dma_gnt   = dma_req & in_dma;
  assign cpu_stall = cpu_req & in_dma;
  assign cpu_rd    = dm_rd;

  // Ownership ends on the last beat, on the beat cap, or when D goes idle.
  assign burst_done = (dma_gnt & dma_last)
                    | (dma_gnt & (beat_cnt == 8'(BURST_MAX - 1)))
                    | ~dma_req;

  // Bad beats are still granted so D drains, but they never reach the DM.
  always_comb begin
    dm_we   = cpu_req & cpu_we;
    dm_addr = cpu_addr;
    dm_wd   = cpu_wd;
    dm_type = cpu_type;
    if (in_dma) begin
      dm_we   = dma_gnt & dma_we & ~bad;
      dm_addr = dma_addr;
      dm_wd   = dma_wd;
      dm_type = Word_DM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CPU;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
      dma_err    <= 1'b0;
    end else begin
      dma_rvalid <= dma_gnt & ~dma_we;
      dma_err    <= dma_gnt & bad;
      if (dma_gnt & ~dma_we)
        dma_rdata <= bad ? 32'h0 : dm_rd;

      case (state)
        S_CPU: begin
          // The C access in the deciding cycle still completes: the switch
          // only takes effect at this edge.
          if (dma_req & (~cpu_req | (wait_cnt == 8'(MAX_WAIT - 1)))) begin
            state    <= S_DMA;
            wait_cnt <= '0;
            beat_cnt <= '0;
          end else if (!dma_req) begin
            wait_cnt <= '0;
          end else if (cpu_req && (wait_cnt < 8'(MAX_WAIT - 1))) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DMA: begin
          if (burst_done) begin
            // wait_cnt restarts so a busy C gets cycles before D re-enters.
            state    <= S_CPU;
            beat_cnt <= '0;
            wait_cnt <= '0;
          end else if (dma_gnt) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: state <= S_CPU;
      endcase
    end
  end

  assign dbg_state    = state;
  assign dbg_wait_cnt = wait_cnt;
  assign dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a 3072-word DM model attached.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wd;
  logic [5:0]  cpu_type;
  logic [31:0] cpu_rd;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_last;
  logic [31:0] dma_addr, dma_wd;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic [31:0] dma_rdata;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wd, dm_rd;
  logic [5:0]  dm_type;
  arb_state_t  dbg_state;
  logic [7:0]  dbg_wait_cnt, dbg_beat_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_type(cpu_type), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .dma_err(dma_err),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_type(dm_type),
    .dm_rd(dm_rd),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt), .dbg_beat_cnt(dbg_beat_cnt)
  );

  // ---------------- DM model ----------------
  // Reset fills each word with a recognisable pattern: 0xA500_0000 ^ index.
  logic [31:0] mem [0:3071];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3072; i++) mem[i] <= 32'hA500_0000 ^ 32'(i);
    end else if (dm_we && dm_addr <= 32'h2FFF) begin
      mem[dm_addr[13:2]] <= dm_wd;
    end
  end

  assign dm_rd = (dm_addr <= 32'h2FFF) ? mem[dm_addr[13:2]] : 32'h0;

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dma_idle;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wd = 0; dma_last = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic       prev_gnt;
    logic       exp_g;
    int         k;
    logic [31:0] word_idx;

    reset = 1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0; cpu_type = Word_DM;
    dma_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    #1;
    // Reset state
    check("rst_state",   32'(dbg_state), 32'(S_CPU));
    check("rst_wait",    32'(dbg_wait_cnt), 32'd0);
    check("rst_beat",    32'(dbg_beat_cnt), 32'd0);
    check("rst_rvalid",  32'(dma_rvalid), 32'd0);
    check("rst_rdata",   dma_rdata, 32'd0);
    check("rst_err",     32'(dma_err), 32'd0);
    check("rst_stall",   32'(cpu_stall), 32'd0);
    tick();

    // C store then load, D idle
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wd = 32'h1234_5678;
    #1;
    check("c_st_we",    32'(dm_we), 32'd1);
    check("c_st_addr",  dm_addr, 32'h10);
    check("c_st_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_we = 0; cpu_wd = 0;
    #1;
    check("c_ld_we",    32'(dm_we), 32'd0);
    check("c_ld_rd",    cpu_rd, 32'h1234_5678);
    check("c_ld_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_req = 0;
    tick();

    // D 3-beat write burst, C idle
    dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_wd = 32'hAAAA_0001;
    #1;
    check("wb_c0_gnt",   32'(dma_gnt), 32'd0);
    check("wb_c0_state", 32'(dbg_state), 32'(S_CPU));
    tick();
    #1;
    check("wb_c1_gnt",   32'(dma_gnt), 32'd1);
    check("wb_c1_we",    32'(dm_we), 32'd1);
    check("wb_c1_addr",  dm_addr, 32'h100);
    check("wb_c1_type",  32'(dm_type), 32'(Word_DM));
    tick();
    dma_addr = 32'h104; dma_wd = 32'hAAAA_0002;
    #1;
    check("wb_c2_gnt",   32'(dma_gnt), 32'd1);
    tick();
    dma_addr = 32'h108; dma_wd = 32'hAAAA_0003; dma_last = 1;
    #1;
    check("wb_c3_gnt",   32'(dma_gnt), 32'd1);
    tick();
    dma_idle();
    #1;
    check("wb_c4_state", 32'(dbg_state), 32'(S_CPU));
    check("wb_c4_gnt",   32'(dma_gnt), 32'd0);
    check("wb_mem0",     mem[32'h40], 32'hAAAA_0001);
    check("wb_mem1",     mem[32'h41], 32'hAAAA_0002);
    check("wb_mem2",     mem[32'h42], 32'hAAAA_0003);
    tick();

    // Aging: C requests every cycle, D from cycle 0 (2-beat read burst)
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dma_req = 1; dma_we = 0; dma_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("age_stall", 32'(cpu_stall), 32'd0);
      check("age_gnt",   32'(dma_gnt), 32'd0);
      check("age_wait",  32'(dbg_wait_cnt), 32'(i));
      check("age_cpurd", cpu_rd, 32'h1234_5678);
      tick();
    end
    #1;
    check("age_c4_state", 32'(dbg_state), 32'(S_DMA));
    check("age_c4_stall", 32'(cpu_stall), 32'd1);
    check("age_c4_gnt",   32'(dma_gnt), 32'd1);
    check("age_c4_addr",  dm_addr, 32'h100);
    tick();
    dma_addr = 32'h104; dma_last = 1;
    #1;
    check("age_c5_rvalid", 32'(dma_rvalid), 32'd1);
    check("age_c5_rdata",  dma_rdata, 32'hAAAA_0001);
    check("age_c5_stall",  32'(cpu_stall), 32'd1);
    check("age_c5_gnt",    32'(dma_gnt), 32'd1);
    tick();
    dma_idle();
    #1;
    check("age_c6_state",  32'(dbg_state), 32'(S_CPU));
    check("age_c6_stall",  32'(cpu_stall), 32'd0);
    check("age_c6_rvalid", 32'(dma_rvalid), 32'd1);
    check("age_c6_rdata",  dma_rdata, 32'hAAAA_0002);
    cpu_req = 0;
    tick();

    // 10-beat read burst at 0x200 with dma_last never set:
    // grants on cycles 1-8, re-arbitration on 9, remaining grants 10-11.
    k = 0;
    prev_gnt = 0;
    for (int c = 0; c <= 12; c++) begin
      dma_req  = (k < 10);
      dma_we   = 0;
      dma_addr = 32'h200 + 32'(4 * k);
      #1;
      exp_g = ((c >= 1) && (c <= 8)) || (c == 10) || (c == 11);
      check("rb_gnt", 32'(dma_gnt), 32'(exp_g));
      if (c == 9) check("rb_rearb_state", 32'(dbg_state), 32'(S_CPU));
      if (prev_gnt) begin
        check("rb_rvalid", 32'(dma_rvalid), 32'd1);
        if (exp_q.size() > 0) check("rb_rdata", dma_rdata, exp_q.pop_front());
        else check("rb_queue", 32'(exp_q.size()), 32'd1);
      end else begin
        check("rb_rvalid_idle", 32'(dma_rvalid), 32'd0);
      end
      prev_gnt = dma_gnt;
      if (dma_gnt) begin
        word_idx = 32'h80 + 32'(k);
        exp_q.push_back(32'hA500_0000 ^ word_idx);
        k++;
      end
      tick();
    end
    check("rb_beats", 32'(k), 32'd10);
    check("rb_q_empty", 32'(exp_q.size()), 32'd0);
    dma_idle();
    tick();

    // Bad write above the limit
    dma_req = 1; dma_we = 1; dma_addr = 32'h3000; dma_wd = 32'hDEAD_0001; dma_last = 1;
    #1;
    check("bw1_c0_gnt", 32'(dma_gnt), 32'd0);
    tick();
    #1;
    check("bw1_gnt", 32'(dma_gnt), 32'd1);
    check("bw1_we",  32'(dm_we), 32'd0);
    tick();
    dma_idle();
    #1;
    check("bw1_err",   32'(dma_err), 32'd1);
    check("bw1_state", 32'(dbg_state), 32'(S_CPU));
    tick();

    // Bad misaligned write onto word 0x40
    dma_req = 1; dma_we = 1; dma_addr = 32'h102; dma_wd = 32'hDEAD_0002; dma_last = 1;
    tick();
    #1;
    check("bw2_gnt", 32'(dma_gnt), 32'd1);
    check("bw2_we",  32'(dm_we), 32'd0);
    tick();
    dma_idle();
    #1;
    check("bw2_err", 32'(dma_err), 32'd1);
    check("bw2_mem", mem[32'h40], 32'hAAAA_0001);
    tick();

    // Bad misaligned read returns 0 although the DM word is nonzero
    dma_req = 1; dma_we = 0; dma_addr = 32'h101; dma_last = 1;
    tick();
    #1;
    check("br_gnt", 32'(dma_gnt), 32'd1);
    tick();
    dma_idle();
    #1;
    check("br_rvalid", 32'(dma_rvalid), 32'd1);
    check("br_rdata",  dma_rdata, 32'h0);
    check("br_err",    32'(dma_err), 32'd1);
    tick();

    // Reset on the 2nd beat of a read burst
    dma_req = 1; dma_we = 0; dma_addr = 32'h180;
    #1;
    check("rm_c0_gnt", 32'(dma_gnt), 32'd0);
    tick();
    #1;
    check("rm_b1_gnt", 32'(dma_gnt), 32'd1);
    tick();
    dma_addr = 32'h184;
    reset = 1;
    tick();
    reset = 0;
    #1;
    check("rm_state",  32'(dbg_state), 32'(S_CPU));
    check("rm_gnt",    32'(dma_gnt), 32'd0);
    check("rm_rvalid", 32'(dma_rvalid), 32'd0);
    check("rm_wait",   32'(dbg_wait_cnt), 32'd0);
    check("rm_beat",   32'(dbg_beat_cnt), 32'd0);
    dma_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
